// File: rtl/mem_port_arbiter.sv
// Arbitrates NCH pipeline requesters onto one need_to_work/work_done memory port,
// with fixed or round-robin priority, per-channel hold/done and a BUSY timeout.
module mem_port_arbiter #(
  parameter int NCH     = 2,
  parameter int AW      = 18,
  parameter int DW      = 16,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_wr,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_hold,
  output logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_err,
  output logic [DW-1:0]     ch_rdata,
  output logic              mem_need_to_work,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_value,
  input  logic              mem_work_done,
  input  logic [DW-1:0]     mem_result,
  output logic [1:0]        dbg_state
);

  localparam int IW = $clog2(NCH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [IW-1:0]   win;
  logic [IW-1:0]   idx_c;
  logic            found;

  // Channel index reached by stepping 'off' places from 'base', wrapping at NCH.
  function automatic logic [IW-1:0] scan_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NCH;
    return IW'(s);
  endfunction

  // Fixed priority is the same scan anchored at channel 0.
  always_comb begin
    win   = '0;
    idx_c = '0;
    found = 1'b0;
    for (int off = 0; off < NCH; off++) begin
      idx_c = scan_idx((RR_MODE != 0) ? rr_ptr_q : '0, off);
      if (!found && ch_req[idx_c]) begin
        found = 1'b1;
        win   = idx_c;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (|ch_req) begin
          gnt_d   = win;
          wr_d    = ch_wr[win];
          addr_d  = ch_addr[int'(win)*AW +: AW];
          wdata_d = ch_wdata[int'(win)*DW +: DW];
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 32'd1;
        // Completion wins over a timeout landing in the same cycle.
        if (mem_work_done) begin
          if (!wr_q) rdata_d = mem_result;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (RR_MODE != 0) rr_ptr_d = scan_idx(gnt_q, 1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Downstream outputs decode straight from state so reset clears them without a clock.
  always_comb begin
    mem_need_to_work = (state_q == S_BUSY);
    mem_rd           = (state_q == S_BUSY) & ~wr_q;
    mem_wr           = (state_q == S_BUSY) & wr_q;
    mem_addr         = (state_q == S_BUSY) ? addr_q : '0;
    mem_value        = (state_q == S_BUSY) ? wdata_q : '0;
    ch_done          = '0;
    ch_err           = '0;
    if (state_q == S_DONE) begin
      ch_done[gnt_q] = 1'b1;
      ch_err[gnt_q]  = err_q;
    end
  end

  assign ch_hold   = ch_req & ~ch_done;
  assign ch_rdata  = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a fixed-priority and a round-robin instance share stimulus
// and are compared every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int TO  = 4;
  localparam logic [NCH-1:0] ONE = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NCH-1:0]    req, wr;
  logic [AW-1:0]     addr [NCH];
  logic [DW-1:0]     wdat [NCH];
  logic [NCH*AW-1:0] addr_bus;
  logic [NCH*DW-1:0] wdata_bus;
  logic              wd;
  logic [DW-1:0]     res;

  always_comb begin
    addr_bus  = '0;
    wdata_bus = '0;
    for (int i = 0; i < NCH; i++) begin
      addr_bus[i*AW +: AW]  = addr[i];
      wdata_bus[i*DW +: DW] = wdat[i];
    end
  end

  logic [NCH-1:0] hold_f, done_f, err_f, hold_r, done_r, err_r;
  logic [DW-1:0]  rdata_f, value_f, rdata_r, value_r;
  logic [AW-1:0]  maddr_f, maddr_r;
  logic           need_f, rd_f, wr_f, need_r, rd_r, wr_r;
  logic [1:0]     dbg_f, dbg_r;

  mem_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RR_MODE(0), .TIMEOUT(TO)) u_fix (
    .clk(clk), .rst(rst), .ch_req(req), .ch_wr(wr), .ch_addr(addr_bus), .ch_wdata(wdata_bus),
    .ch_hold(hold_f), .ch_done(done_f), .ch_err(err_f), .ch_rdata(rdata_f),
    .mem_need_to_work(need_f), .mem_rd(rd_f), .mem_wr(wr_f), .mem_addr(maddr_f),
    .mem_value(value_f), .mem_work_done(wd), .mem_result(res), .dbg_state(dbg_f));

  mem_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RR_MODE(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst(rst), .ch_req(req), .ch_wr(wr), .ch_addr(addr_bus), .ch_wdata(wdata_bus),
    .ch_hold(hold_r), .ch_done(done_r), .ch_err(err_r), .ch_rdata(rdata_r),
    .mem_need_to_work(need_r), .mem_rd(rd_r), .mem_wr(wr_r), .mem_addr(maddr_r),
    .mem_value(value_r), .mem_work_done(wd), .mem_result(res), .dbg_state(dbg_r));

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [NCH-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model (index 0 = fixed, 1 = round-robin) ----------------
  int             ph   [2];   // 0 waiting, 1 memory access in flight, 2 completion cycle
  int             gnt  [2];
  int             rrp  [2];
  int             age  [2];   // BUSY cycles already spent on the current access
  bit             wl   [2];
  bit             el   [2];
  logic [AW-1:0]  al   [2];
  logic [DW-1:0]  dl   [2];
  logic [DW-1:0]  rdm  [2];

  function automatic int pick(input logic [NCH-1:0] r, input int rr, input int ptr);
    for (int off = 0; off < NCH; off++) begin
      int idx;
      idx = (rr != 0) ? (ptr + off) % NCH : off;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; gnt[k] = 0; rrp[k] = 0; age[k] = 0;
      wl[k] = 0; el[k] = 0; al[k] = '0; dl[k] = '0; rdm[k] = '0;
    end
  endtask

  // Advance the model across the coming rising edge using the inputs now on the pins.
  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      case (ph[k])
        0: if (req != '0) begin
          gnt[k] = pick(req, k, rrp[k]);
          wl[k]  = wr[gnt[k]];
          al[k]  = addr[gnt[k]];
          dl[k]  = wdat[gnt[k]];
          age[k] = 0;
          ph[k]  = 1;
        end
        1: begin
          age[k]++;
          if (wd) begin
            if (!wl[k]) rdm[k] = res;
            el[k] = 0;
            ph[k] = 2;
          end else if (TO != 0 && age[k] == TO) begin
            el[k] = 1;
            ph[k] = 2;
          end
        end
        default: begin
          ph[k] = 0;
          if (k == 1) rrp[k] = (gnt[k] + 1) % NCH;
        end
      endcase
    end
  endtask

  task automatic compare_one(input int k, input logic [NCH-1:0] h, d, e,
                             input logic [DW-1:0] rdat, input logic nd, mr, mw,
                             input logic [AW-1:0] ma, input logic [DW-1:0] mv);
    logic [NCH-1:0] ed, ee;
    bit busy;
    busy = (ph[k] == 1);
    ed   = (ph[k] == 2) ? (ONE << gnt[k]) : '0;
    ee   = (ph[k] == 2 && el[k]) ? ed : '0;
    chk($sformatf("hold[%0d]", k),  32'(h),    32'(req & ~ed));
    chk($sformatf("done[%0d]", k),  32'(d),    32'(ed));
    chk($sformatf("err[%0d]", k),   32'(e),    32'(ee));
    chk($sformatf("rdata[%0d]", k), 32'(rdat), 32'(rdm[k]));
    chk($sformatf("need[%0d]", k),  32'(nd),   32'(busy));
    chk($sformatf("rd[%0d]", k),    32'(mr),   32'(busy && !wl[k]));
    chk($sformatf("wr[%0d]", k),    32'(mw),   32'(busy && wl[k]));
    chk($sformatf("maddr[%0d]", k), 32'(ma),   busy ? 32'(al[k]) : 32'd0);
    chk($sformatf("mval[%0d]", k),  32'(mv),   busy ? 32'(dl[k]) : 32'd0);
  endtask

  task automatic compare_all();
    compare_one(0, hold_f, done_f, err_f, rdata_f, need_f, rd_f, wr_f, maddr_f, value_f);
    compare_one(1, hold_r, done_r, err_r, rdata_r, need_r, rd_r, wr_r, maddr_r, value_r);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; leaves the bench at the next falling edge, checked.
  task automatic cyc(input logic [NCH-1:0] r, input logic [NCH-1:0] w,
                     input logic d, input logic [DW-1:0] rs);
    req = r; wr = w; wd = d; res = rs;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic contend(input logic [NCH-1:0] r, input logic [NCH-1:0] fix_exp);
    logic [NCH-1:0] e;
    for (int t = 0; t < 4; t++) begin
      cyc(r, '0, 1'b0, '0);
      chk("cont_fix_hold", 32'(hold_f), 32'(r));
      cyc(r, '0, 1'b1, DW'(t));
      chk("cont_fix_done", 32'(done_f), 32'(fix_exp));
      chk("cont_fix_hold_other", 32'(hold_f), 32'(r & ~fix_exp));
      e = exp_q.pop_front();
      chk("cont_rr_done", 32'(done_r), 32'(e));
      cyc(r, '0, 1'b0, '0);
    end
    cyc('0, '0, 1'b0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int p;
    rst = 1'b1; req = '0; wr = '0; wd = 1'b0; res = '0;
    for (int i = 0; i < NCH; i++) begin addr[i] = '0; wdat[i] = '0; end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    chk("rst_need", 32'({need_f, need_r}), 32'd0);
    chk("rst_rdata", 32'(rdata_r), 32'd0);
    rst = 1'b0;

    // Single read on channel 0.
    addr[0] = 18'h00123;
    cyc(4'b0001, '0, 1'b0, '0);
    chk("rd_strobe", 32'({rd_f, rd_r}), 32'b11);
    chk("rd_addr", 32'(maddr_f), 32'h00123);
    chk("rd_hold", 32'(hold_r), 32'b0001);
    cyc(4'b0001, '0, 1'b0, '0);
    cyc(4'b0001, '0, 1'b1, 16'hBEEF);
    chk("rd_done_fix", 32'(done_f), 32'b0001);
    chk("rd_done_rr", 32'(done_r), 32'b0001);
    chk("rd_data", 32'(rdata_f), 32'hBEEF);
    cyc('0, '0, 1'b0, '0);

    // Write on channel 1: read data register must not move.
    addr[1] = 18'h0BF00; wdat[1] = 16'h0041;
    cyc(4'b0010, 4'b0010, 1'b0, '0);
    chk("wr_strobes", 32'({wr_f, rd_f}), 32'b10);
    chk("wr_value", 32'(value_r), 32'h0041);
    chk("wr_addr", 32'(maddr_r), 32'h0BF00);
    cyc(4'b0010, 4'b0010, 1'b1, 16'h1234);
    chk("wr_done", 32'(done_f), 32'b0010);
    chk("wr_rdata_kept", 32'(rdata_r), 32'hBEEF);
    cyc('0, '0, 1'b0, '0);

    // Timeout on channel 2 with no completion.
    cyc(4'b0100, '0, 1'b0, '0);
    nb = 0;
    for (int i = 0; i < 10 && done_f == '0; i++) begin
      if (need_f) nb++;
      cyc(4'b0100, '0, 1'b0, '0);
    end
    chk("to_busy_cycles", 32'(nb), 32'd4);
    chk("to_done", 32'(done_f), 32'b0100);
    chk("to_err_fix", 32'(err_f), 32'b0100);
    chk("to_err_rr", 32'(err_r), 32'b0100);
    chk("to_rdata_kept", 32'(rdata_f), 32'hBEEF);
    cyc('0, '0, 1'b0, '0);

    // Completion coincident with the timeout cycle.
    cyc(4'b0100, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cyc(4'b0100, '0, 1'b0, '0);
    cyc(4'b0100, '0, 1'b1, 16'h5A5A);
    chk("co_done", 32'(done_r), 32'b0100);
    chk("co_err", 32'({err_f, err_r}), 32'd0);
    chk("co_rdata", 32'(rdata_r), 32'h5A5A);
    cyc('0, '0, 1'b0, '0);

    // Contention on channels 0 and 1; round-robin pointer now sits at 3.
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    contend(4'b0011, 4'b0001);

    // Reset in the second BUSY cycle.
    cyc(4'b0011, '0, 1'b0, '0);
    cyc(4'b0011, '0, 1'b0, '0);
    rst = 1'b1;
    #1;
    chk("arst_need", 32'({need_f, need_r}), 32'd0);
    chk("arst_rd", 32'({rd_f, rd_r}), 32'd0);
    chk("arst_wr", 32'({wr_f, wr_r}), 32'd0);
    model_reset();
    compare_all();
    cyc(4'b0011, '0, 1'b1, 16'h7777);
    chk("arst_no_done", 32'({done_f, done_r}), 32'd0);
    rst = 1'b0;
    cyc(4'b0011, '0, 1'b0, '0);
    cyc(4'b0011, '0, 1'b1, 16'h0101);
    chk("arst_rr_first", 32'(done_r), 32'b0001);
    cyc('0, '0, 1'b0, '0);

    // Sparse requests 1010 alternate 1,3 in round-robin; channel 1 always wins fixed.
    exp_q.push_back(4'b0010); exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010); exp_q.push_back(4'b1000);
    contend(4'b1010, 4'b0010);

    // Randomised traffic, including stray work_done, operand churn, timeouts and resets.
    for (int c = 0; c < 3000; c++) begin
      logic [NCH-1:0] r, w;
      p = ((c / 500) % 3 == 0) ? 40 : (((c / 500) % 3 == 1) ? 8 : 0);
      r = ($urandom_range(0, 3) == 0) ? NCH'($urandom_range(0, 15)) : req;
      w = NCH'($urandom_range(0, 15));
      for (int i = 0; i < NCH; i++) begin
        addr[i] = AW'($urandom);
        wdat[i] = DW'($urandom);
      end
      rst = ($urandom_range(0, 599) == 0);
      cyc(r, w, ($urandom_range(0, 99) < p), DW'($urandom));
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
